// File: rtl/reflex_game_ctrl.sv
// reflex_game_ctrl: session FSM, obstacle spawn scheduling, speed ramp, lives, score and reaction timing
module reflex_game_ctrl #(
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int LIVES_INIT       = 10,
    parameter int SPAWN_GAP_MIN    = 30,
    parameter int LANE_X_MIN       = 395,
    parameter int SPEED_INIT       = 4,
    parameter int SPEED_MAX        = 20,
    parameter int SPEEDUP_EVERY    = 5,
    parameter int HIT_FLASH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       collision,
    input  logic       obstacle_done,
    input  logic       dodge,
    output logic [2:0] state,
    output logic       spawn,
    output logic [9:0] obstacle_x,
    output logic [4:0] obstacle_speed,
    output logic [3:0] lives,
    output logic [7:0] passed_cnt,
    output logic [7:0] react_frames,
    output logic       react_valid
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CD   = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_HIT  = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    logic [15:0] lfsr;
    logic [2:0]  state_d;
    logic        active, dodge_seen;
    logic [15:0] cd_cnt, gap_cnt, hit_cnt, gap_load;
    logic [7:0]  react_cnt, step_cnt;
    logic        run_act, ev_start, ev_cd_end, ev_spawn, ev_col, ev_done, ev_dodge, ev_hit_end;

    assign gap_load = 16'(SPAWN_GAP_MIN) + {10'd0, lfsr[5:0]};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;

    always_comb begin
        state_d = (state > S_OVER) ? S_IDLE :
                  ev_start         ? S_CD :
                  ev_cd_end        ? S_RUN :
                  ev_col           ? ((lives == 4'd1) ? S_OVER : S_HIT) :
                  ev_hit_end       ? S_RUN : state;
    end

    // Every event is pre-gated by state so the datapath below only sees legal ones
    always_comb begin
        run_act    = (state == S_RUN) && active;
        ev_start   = start && ((state == S_IDLE) || (state == S_OVER));
        ev_cd_end  = (state == S_CD) && frame_tick && (cd_cnt <= 16'd1);
        ev_spawn   = (state == S_RUN) && !active && frame_tick && (gap_cnt <= 16'd1);
        ev_col     = run_act && collision;
        ev_done    = run_act && obstacle_done && !collision;
        ev_dodge   = run_act && dodge && !dodge_seen;
        ev_hit_end = (state == S_HIT) && frame_tick && (hit_cnt <= 16'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spawn          <= 1'b0;
            obstacle_x     <= 10'(LANE_X_MIN);
            obstacle_speed <= 5'(SPEED_INIT);
            lives          <= 4'(LIVES_INIT);
            passed_cnt     <= 8'd0;
            react_frames   <= 8'd0;
            react_valid    <= 1'b0;
            active         <= 1'b0;
            dodge_seen     <= 1'b0;
            cd_cnt         <= 16'd0;
            gap_cnt        <= 16'd0;
            hit_cnt        <= 16'd0;
            react_cnt      <= 8'd0;
            step_cnt       <= 8'd0;
        end else begin
            spawn       <= ev_spawn;
            react_valid <= ev_dodge;
            if (ev_start) begin
                obstacle_x     <= 10'(LANE_X_MIN);
                obstacle_speed <= 5'(SPEED_INIT);
                lives          <= 4'(LIVES_INIT);
                passed_cnt     <= 8'd0;
                react_frames   <= 8'd0;
                active         <= 1'b0;
                dodge_seen     <= 1'b0;
                cd_cnt         <= 16'(COUNTDOWN_FRAMES);
                react_cnt      <= 8'd0;
                step_cnt       <= 8'd0;
            end
            if ((state == S_CD) && frame_tick)
                cd_cnt <= cd_cnt - 16'd1;
            if (ev_cd_end || ev_hit_end)
                gap_cnt <= gap_load;
            if ((state == S_RUN) && !active && frame_tick && (gap_cnt != 16'd0))
                gap_cnt <= gap_cnt - 16'd1;
            if (ev_spawn) begin
                obstacle_x <= 10'(LANE_X_MIN) + {3'd0, lfsr[14:8]};
                active     <= 1'b1;
                react_cnt  <= 8'd0;
                dodge_seen <= 1'b0;
            end
            if (run_act && frame_tick && (react_cnt != 8'hFF))
                react_cnt <= react_cnt + 8'd1;
            if (ev_dodge) begin
                react_frames <= react_cnt;
                dodge_seen   <= 1'b1;
            end
            if (ev_col) begin
                lives   <= lives - 4'd1;
                active  <= 1'b0;
                hit_cnt <= 16'(HIT_FLASH_FRAMES);
            end
            if ((state == S_HIT) && frame_tick)
                hit_cnt <= hit_cnt - 16'd1;
            if (ev_hit_end)
                active <= 1'b0;
            // step_cnt tracks passed_cnt modulo SPEEDUP_EVERY while the score is still counting
            if (ev_done) begin
                active  <= 1'b0;
                gap_cnt <= gap_load;
                if (passed_cnt != 8'hFF) begin
                    passed_cnt <= passed_cnt + 8'd1;
                    step_cnt   <= (step_cnt == 8'(SPEEDUP_EVERY - 1)) ? 8'd0 : step_cnt + 8'd1;
                    if ((step_cnt == 8'(SPEEDUP_EVERY - 1)) && (obstacle_speed < 5'(SPEED_MAX)))
                        obstacle_speed <= obstacle_speed + 5'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_reflex_game_ctrl.sv
// tb_reflex_game_ctrl: directed/randomized bench with an event-level reference model
module tb_reflex_game_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       frame_tick = 1'b0, start = 1'b0, collision = 1'b0, obstacle_done = 1'b0, dodge = 1'b0;
    logic [2:0] state;
    logic       spawn, react_valid;
    logic [9:0] obstacle_x;
    logic [4:0] obstacle_speed;
    logic [3:0] lives;
    logic [7:0] passed_cnt, react_frames;

    int errors = 0, checks = 0;
    int exp_gap, exp_lives, exp_passed, exp_react, k;
    bit idle_en;
    logic [15:0] m, snap;

    reflex_game_ctrl #(
        .COUNTDOWN_FRAMES(180), .LIVES_INIT(10), .SPAWN_GAP_MIN(30), .LANE_X_MIN(395),
        .SPEED_INIT(4), .SPEED_MAX(20), .SPEEDUP_EVERY(5), .HIT_FLASH_FRAMES(60)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .collision(collision),
        .obstacle_done(obstacle_done), .dodge(dodge), .state(state), .spawn(spawn),
        .obstacle_x(obstacle_x), .obstacle_speed(obstacle_speed), .lives(lives),
        .passed_cnt(passed_cnt), .react_frames(react_frames), .react_valid(react_valid)
    );

    always #5 clk = ~clk;

    // Reference pseudo-random source: 16-bit Fibonacci LFSR, taps 16,14,13,11
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= 16'hACE1;
        else        m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};

    function automatic int exp_speed(input int p);
        return (4 + p / 5 > 20) ? 20 : 4 + p / 5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic f, input logic s, input logic c, input logic d, input logic g);
        frame_tick = f; start = s; collision = c; obstacle_done = d; dodge = g;
        snap = m;
        @(negedge clk);
        frame_tick = 0; start = 0; collision = 0; obstacle_done = 0; dodge = 0;
    endtask

    task automatic idle_gap();
        if (idle_en)
            repeat ($urandom_range(0, 2)) begin
                step(0, 0, 0, 0, 0);
                chk("idle_no_spawn", spawn, 0);
            end
    endtask

    task automatic cd_ticks();
        for (int i = 1; i <= 180; i++) begin
            idle_gap();
            step(1, 0, 0, 0, 0);
            chk("countdown_state", state, (i == 180) ? 2 : 1);
            chk("countdown_no_spawn", spawn, 0);
        end
        exp_gap = 30 + int'(snap[5:0]);
    endtask

    task automatic run_to_spawn();
        for (int i = 1; i <= exp_gap; i++) begin
            idle_gap();
            step(1, 0, 0, 0, 0);
            chk("spawn_timing", spawn, (i == exp_gap) ? 1 : 0);
        end
        chk("obstacle_x", obstacle_x, 395 + int'(snap[14:8]));
        chk("x_range", (obstacle_x >= 10'd395 && obstacle_x <= 10'd522), 1);
    endtask

    task automatic done_pass();
        step(0, 0, 0, 1, 0);
        exp_gap = 30 + int'(snap[5:0]);
        exp_passed = (exp_passed < 255) ? exp_passed + 1 : 255;
        chk("passed_cnt", passed_cnt, exp_passed);
        chk("speed", obstacle_speed, exp_speed(exp_passed));
        chk("pass_state", state, 2);
    endtask

    task automatic hit_ticks();
        for (int i = 1; i <= 60; i++) begin
            step(1, 0, 0, 0, 0);
            chk("hit_state", state, (i == 60) ? 2 : 3);
        end
        exp_gap = 30 + int'(snap[5:0]);
    endtask

    initial begin
        exp_lives = 10; exp_passed = 0; exp_react = 0; idle_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_spawn", spawn, 0);
        chk("rst_x", obstacle_x, 395);
        chk("rst_speed", obstacle_speed, 4);
        chk("rst_lives", lives, 10);
        chk("rst_passed", passed_cnt, 0);
        chk("rst_react", react_frames, 0);
        chk("rst_valid", react_valid, 0);
        rst_n = 1;
        step(1, 0, 0, 0, 0);
        chk("idle_tick_ignored", state, 0);
        step(0, 0, 1, 1, 1);
        chk("idle_events_state", state, 0);
        chk("idle_events_lives", lives, 10);
        chk("idle_events_valid", react_valid, 0);
        step(0, 1, 0, 0, 0);
        chk("start_to_cd", state, 1);
        step(0, 1, 0, 0, 0);
        chk("start_ignored_cd", state, 1);
        cd_ticks();
        run_to_spawn();
        step(0, 0, 0, 0, 0);
        chk("spawn_one_clk", spawn, 0);
        repeat (12) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("react_12", react_frames, 12);
        chk("react_valid_pulse", react_valid, 1);
        step(0, 0, 0, 0, 0);
        chk("react_valid_one_clk", react_valid, 0);
        step(1, 0, 0, 0, 1);
        chk("second_dodge_no_pulse", react_valid, 0);
        chk("second_dodge_held", react_frames, 12);
        done_pass();
        for (int p = 2; p <= 83; p++) begin
            run_to_spawn();
            k = $urandom_range(0, 20);
            repeat (k) step(1, 0, 0, 0, 0);
            step(1, 0, 0, 0, 1);
            exp_react = k;
            chk("react_tick_dodge", react_frames, exp_react);
            chk("react_valid", react_valid, 1);
            done_pass();
            if (p == 80) chk("speed_at_80", obstacle_speed, 20);
        end
        run_to_spawn();
        step(0, 0, 1, 1, 0);
        exp_lives--;
        chk("coll_done_lives", lives, exp_lives);
        chk("coll_done_passed", passed_cnt, exp_passed);
        chk("coll_done_state", state, 3);
        step(0, 1, 0, 0, 0);
        chk("start_ignored_hit", state, 3);
        hit_ticks();
        for (int i = 0; i < 9; i++) begin
            run_to_spawn();
            k = $urandom_range(1, 20);
            repeat (k) step(1, 0, 0, 0, 0);
            step(0, 0, 1, 0, (i == 0));
            exp_lives--;
            if (i == 0) begin
                exp_react = k;
                chk("dodge_coll_valid", react_valid, 1);
                chk("dodge_coll_react", react_frames, exp_react);
            end
            chk("coll_lives", lives, exp_lives);
            chk("coll_state", state, (exp_lives == 0) ? 4 : 3);
            if (exp_lives != 0) hit_ticks();
        end
        step(1, 0, 1, 1, 1);
        chk("over_state", state, 4);
        chk("over_lives", lives, 0);
        chk("over_passed", passed_cnt, exp_passed);
        chk("over_react", react_frames, exp_react);
        chk("over_valid", react_valid, 0);
        step(0, 1, 0, 0, 0);
        exp_lives = 10; exp_passed = 0; exp_react = 0;
        chk("restart_state", state, 1);
        chk("restart_lives", lives, 10);
        chk("restart_passed", passed_cnt, 0);
        chk("restart_speed", obstacle_speed, 4);
        chk("restart_react", react_frames, 0);
        cd_ticks();
        run_to_spawn();
        done_pass();
        run_to_spawn();
        #2 rst_n = 0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_spawn", spawn, 0);
        chk("arst_x", obstacle_x, 395);
        chk("arst_passed", passed_cnt, 0);
        chk("arst_lives", lives, 10);
        chk("arst_speed", obstacle_speed, 4);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0, 0, 0);
            chk("post_rst_no_spawn", spawn, 0);
        end
        chk("post_rst_state", state, 0);
        idle_en = 0;
        exp_passed = 0;
        step(0, 1, 0, 0, 0);
        cd_ticks();
        for (int i = 0; i < 600; i++) begin
            run_to_spawn();
            done_pass();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
